// File: rtl/i2s_tdm_clock_if.sv
// Purpose : clock/frame timing bundle between the I2S/TDM clock generator and the
//           serialiser/deserialiser blocks that consume its strobes.
// Ports   : en (+ div when I2S_TDM_CLOCK_RUNTIME_DIV_EN) into the generator;
//           sck, ws, frame_posn, chan, bit_posn, sck_rise, sck_fall, frame_start out.
// Modports: master = generator side, slave = consumer side.
interface i2s_tdm_clock_if #(
  parameter int CHAN_BITS = 32,
  parameter int CHANNELS  = 2
);
  localparam int FRAME = CHANNELS * CHAN_BITS;
  localparam int FW    = ($clog2(FRAME) > 1) ? $clog2(FRAME) : 1;
  localparam int CW    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW    = $clog2(CHAN_BITS);

  logic          en;
`ifdef I2S_TDM_CLOCK_RUNTIME_DIV_EN
  logic [7:0]    div;
`endif
  logic          sck;
  logic          ws;
  logic [FW-1:0] frame_posn;
  logic [CW-1:0] chan;
  logic [BW-1:0] bit_posn;
  logic          sck_rise;
  logic          sck_fall;
  logic          frame_start;

  modport master (
`ifdef I2S_TDM_CLOCK_RUNTIME_DIV_EN
    input  div,
`endif
    input  en,
    output sck, ws, frame_posn, chan, bit_posn, sck_rise, sck_fall, frame_start
  );

  modport slave (
`ifdef I2S_TDM_CLOCK_RUNTIME_DIV_EN
    output div,
`endif
    output en,
    input  sck, ws, frame_posn, chan, bit_posn, sck_rise, sck_fall, frame_start
  );
endinterface

// File: rtl/i2s_tdm_clock.sv
// Purpose : I2S/TDM bit-clock + frame generator; divides ck to sck, tracks frame position, makes ws.
// Latency : sck/ws/strobes are registered one ck behind the prescale/frame_posn counters.
// Backpr. : none; free-running while en=1, en=0 or rst_n=0 forces every output and counter to 0.
// Ports   : ck, rst_n (synchronous, active-low), bus (i2s_tdm_clock_if.master).
// Option  : define I2S_TDM_CLOCK_RUNTIME_DIV_EN to take the divider from bus.div,
//           reloaded only in reset, while idle, or at the frame wrap (min value 2).
module i2s_tdm_clock #(
  parameter int DIVIDER   = 12,
  parameter int CHAN_BITS = 32,
  parameter int CHANNELS  = 2,
  parameter int MODE      = 0,
  parameter int WS_EARLY  = 0
) (
  input logic             ck,
  input logic             rst_n,
  i2s_tdm_clock_if.master bus
);
  localparam int FRAME = CHANNELS * CHAN_BITS;
  localparam int FW    = ($clog2(FRAME) > 1) ? $clog2(FRAME) : 1;
  localparam int CW    = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW    = $clog2(CHAN_BITS);
`ifdef I2S_TDM_CLOCK_RUNTIME_DIV_EN
  localparam int PW    = 8;
`else
  localparam int PW    = ($clog2(DIVIDER) > 1) ? $clog2(DIVIDER) : 1;
`endif

  localparam logic [FW-1:0] POSN_LAST  = FW'(FRAME - 1);
  localparam logic [FW-1:0] POSN_RIGHT = FW'(CHAN_BITS);

  logic [PW-1:0] prescale_q, prescale_d;
  logic [FW-1:0] frame_posn_q, frame_posn_d;
  logic          sck_q, sck_d;
  logic          ws_q, ws_d;
  logic          sck_rise_q, sck_rise_d;
  logic          sck_fall_q, sck_fall_d;
  logic          frame_start_q, frame_start_d;

  logic [PW-1:0] pre_last;   // D-1
  logic [PW-1:0] pre_half;   // D/2, first prescale value with sck high
  logic          pre_wrap;
  logic          posn_wrap;
  logic [FW-1:0] ws_posn;

`ifdef I2S_TDM_CLOCK_RUNTIME_DIV_EN
  logic [PW-1:0] div_q, div_d;
  logic [PW-1:0] div_load;

  assign div_load = (bus.div < 8'd2) ? 8'd2 : bus.div;

  // The divider only changes when no frame is in flight or exactly at the
  // frame boundary, so sck never produces a runt period mid-frame.
  always_comb begin
    div_d = div_q;
    if (!bus.en || posn_wrap) div_d = div_load;
  end

  always_ff @(posedge ck) begin
    if (!rst_n) div_q <= div_load;
    else        div_q <= div_d;
  end

  assign pre_last = div_q - 8'd1;
  assign pre_half = div_q >> 1;
`else
  assign pre_last = PW'(DIVIDER - 1);
  assign pre_half = PW'(DIVIDER / 2);
`endif

  assign pre_wrap  = (prescale_q == pre_last);
  assign posn_wrap = pre_wrap && (frame_posn_q == POSN_LAST);

  always_comb begin
    prescale_d    = '0;
    frame_posn_d  = '0;
    sck_d         = 1'b0;
    ws_d          = 1'b0;
    sck_rise_d    = 1'b0;
    sck_fall_d    = 1'b0;
    frame_start_d = 1'b0;

    // Philips alignment: ws looks one bit ahead, wrapping at the frame end
    // (the frame length need not be a power of two).
    if (WS_EARLY != 0) ws_posn = (frame_posn_q == POSN_LAST) ? '0 : frame_posn_q + 1'b1;
    else               ws_posn = frame_posn_q;

    if (bus.en) begin
      prescale_d = pre_wrap ? '0 : prescale_q + 1'b1;
      if (pre_wrap) frame_posn_d = posn_wrap ? '0 : frame_posn_q + 1'b1;
      else          frame_posn_d = frame_posn_q;

      sck_d = (prescale_q >= pre_half);
      if (MODE == 1) ws_d = (ws_posn == '0);
      else           ws_d = (ws_posn >= POSN_RIGHT);

      // Compare next sck with current sck so each strobe lands in the first
      // cycle the new sck level is visible.
      sck_rise_d    = sck_d & ~sck_q;
      sck_fall_d    = ~sck_d & sck_q;
      frame_start_d = posn_wrap;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      prescale_q    <= '0;
      frame_posn_q  <= '0;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      sck_rise_q    <= 1'b0;
      sck_fall_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      prescale_q    <= prescale_d;
      frame_posn_q  <= frame_posn_d;
      sck_q         <= sck_d;
      ws_q          <= ws_d;
      sck_rise_q    <= sck_rise_d;
      sck_fall_q    <= sck_fall_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.sck         = sck_q;
  assign bus.ws          = ws_q;
  assign bus.frame_posn  = frame_posn_q;
  // CHAN_BITS is a power of two, so slot/bit are a shift and a slice.
  assign bus.chan        = CW'(frame_posn_q >> BW);
  assign bus.bit_posn    = frame_posn_q[BW-1:0];
  assign bus.sck_rise    = sck_rise_q;
  assign bus.sck_fall    = sck_fall_q;
  assign bus.frame_start = frame_start_q;
endmodule
